// File: rtl/vjdot_accum_if.sv
// Handshake and data bundle for the vj accumulation stage: upstream
// valid/ready with the operands, and downstream valid/ready with the link acceleration.
interface vjdot_accum_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 3
);
    logic                    valid_in;
    logic                    ready_out;
    logic signed [WIDTH-1:0] xa_in_AX, xa_in_AY, xa_in_AZ, xa_in_LX, xa_in_LY, xa_in_LZ;
    logic signed [WIDTH-1:0] vjvec_in_AX, vjvec_in_AY, vjvec_in_AZ;
    logic signed [WIDTH-1:0] vjvec_in_LX, vjvec_in_LY, vjvec_in_LZ;
    logic signed [WIDTH-1:0] qdd_in;
    logic signed [WIDTH-1:0] acc_out_AX, acc_out_AY, acc_out_AZ, acc_out_LX, acc_out_LY, acc_out_LZ;
    logic                    valid_out;
    logic                    ready_in;
    logic [CNT_W-1:0]        link_out;
    logic                    last_out;
    logic                    sat_out;

    modport slave (
        input  valid_in, xa_in_AX, xa_in_AY, xa_in_AZ, xa_in_LX, xa_in_LY, xa_in_LZ,
        input  vjvec_in_AX, vjvec_in_AY, vjvec_in_AZ, vjvec_in_LX, vjvec_in_LY, vjvec_in_LZ,
        input  qdd_in, ready_in,
        output ready_out, acc_out_AX, acc_out_AY, acc_out_AZ, acc_out_LX, acc_out_LY, acc_out_LZ,
        output valid_out, link_out, last_out, sat_out
    );

    modport master (
        output valid_in, xa_in_AX, xa_in_AY, xa_in_AZ, xa_in_LX, xa_in_LY, xa_in_LZ,
        output vjvec_in_AX, vjvec_in_AY, vjvec_in_AZ, vjvec_in_LX, vjvec_in_LY, vjvec_in_LZ,
        output qdd_in, ready_in,
        input  ready_out, acc_out_AX, acc_out_AY, acc_out_AZ, acc_out_LX, acc_out_LY, acc_out_LZ,
        input  valid_out, link_out, last_out, sat_out
    );
endinterface

// File: rtl/vjdot_accum.sv
// Link acceleration = parent accel + vj term, with qdd added on the joint axis (AZ),
// through a 2-stage saturating valid/ready pipeline with link tagging and a per-pass sticky saturation flag.
module vjdot_accum #(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16,
    parameter int NUM_LINKS    = 7,
    parameter int CNT_W        = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    vjdot_accum_if.slave  bus
);
    localparam logic [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_LINK = CNT_W'(NUM_LINKS - 1);

    generate
        if (NUM_LINKS < 1 || (1 << CNT_W) < NUM_LINKS || DECIMAL_BITS >= WIDTH) begin : gBadParams
            $error("vjdot_accum: invalid parameter combination");
        end
    endgenerate

    // Result MSB is the saturation flag; the sum is formed one bit wider so overflow is visible.
    function automatic logic [WIDTH:0] satAdd(input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? SAT_MIN : SAT_MAX)};
        return {1'b0, s[WIDTH-1:0]};
    endfunction

    logic [WIDTH-1:0] xaIn [6];
    logic [WIDTH-1:0] vjIn [6];
    logic [WIDTH:0]   s1Res [6];
    logic [WIDTH:0]   azRes;
    logic             entrySat1, entrySat2;
    logic             s1Load, s2Load, inXfer;

    logic             s1Valid_q, s1Last_q, s1Sat_q;
    logic [WIDTH-1:0] s1Data_q [6];
    logic [WIDTH-1:0] s1Qdd_q;
    logic [CNT_W-1:0] s1Link_q;
    logic             s2Valid_q, s2Last_q, sat_q, sat_d;
    logic [WIDTH-1:0] acc_q [6];
    logic [CNT_W-1:0] s2Link_q;
    logic [CNT_W-1:0] linkCnt_q, linkCnt_d;

    assign xaIn[0] = bus.xa_in_AX;    assign xaIn[1] = bus.xa_in_AY;    assign xaIn[2] = bus.xa_in_AZ;
    assign xaIn[3] = bus.xa_in_LX;    assign xaIn[4] = bus.xa_in_LY;    assign xaIn[5] = bus.xa_in_LZ;
    assign vjIn[0] = bus.vjvec_in_AX; assign vjIn[1] = bus.vjvec_in_AY; assign vjIn[2] = bus.vjvec_in_AZ;
    assign vjIn[3] = bus.vjvec_in_LX; assign vjIn[4] = bus.vjvec_in_LY; assign vjIn[5] = bus.vjvec_in_LZ;

    for (genvar k = 0; k < 6; k++) begin : gStage1Sum
        assign s1Res[k] = satAdd(xaIn[k], vjIn[k]);
    end

    assign entrySat1 = s1Res[0][WIDTH] | s1Res[1][WIDTH] | s1Res[2][WIDTH]
                     | s1Res[3][WIDTH] | s1Res[4][WIDTH] | s1Res[5][WIDTH];
    assign azRes     = satAdd(s1Data_q[2], s1Qdd_q);
    assign entrySat2 = s1Sat_q | azRes[WIDTH];

    assign s2Load    = !s2Valid_q || bus.ready_in;
    assign s1Load    = !s1Valid_q || s2Load;
    assign inXfer    = bus.valid_in && s1Load;
    assign linkCnt_d = (linkCnt_q == LAST_LINK) ? '0 : linkCnt_q + 1'b1;
    // Link 0 opens a new pass, so the sticky flag restarts from that entry alone.
    assign sat_d     = (s1Link_q == '0) ? entrySat2 : (sat_q | entrySat2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1Valid_q <= 1'b0;
            s1Last_q  <= 1'b0;
            s1Sat_q   <= 1'b0;
            s1Qdd_q   <= '0;
            s1Link_q  <= '0;
            linkCnt_q <= '0;
            for (int k = 0; k < 6; k++) s1Data_q[k] <= '0;
        end else begin
            if (s1Load) s1Valid_q <= bus.valid_in;
            if (inXfer) begin
                for (int k = 0; k < 6; k++) s1Data_q[k] <= s1Res[k][WIDTH-1:0];
                s1Qdd_q   <= bus.qdd_in;
                s1Link_q  <= linkCnt_q;
                s1Last_q  <= (linkCnt_q == LAST_LINK);
                s1Sat_q   <= entrySat1;
                linkCnt_q <= linkCnt_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2Valid_q <= 1'b0;
            s2Last_q  <= 1'b0;
            s2Link_q  <= '0;
            sat_q     <= 1'b0;
            for (int k = 0; k < 6; k++) acc_q[k] <= '0;
        end else begin
            if (s2Load) s2Valid_q <= s1Valid_q;
            if (s2Load && s1Valid_q) begin
                for (int k = 0; k < 6; k++) acc_q[k] <= s1Data_q[k];
                acc_q[2] <= azRes[WIDTH-1:0];
                s2Link_q <= s1Link_q;
                s2Last_q <= s1Last_q;
                sat_q    <= sat_d;
            end
        end
    end

    assign bus.ready_out  = s1Load;
    assign bus.valid_out  = s2Valid_q;
    assign bus.link_out   = s2Link_q;
    assign bus.last_out   = s2Last_q;
    assign bus.sat_out    = sat_q;
    assign bus.acc_out_AX = acc_q[0];
    assign bus.acc_out_AY = acc_q[1];
    assign bus.acc_out_AZ = acc_q[2];
    assign bus.acc_out_LX = acc_q[3];
    assign bus.acc_out_LY = acc_q[4];
    assign bus.acc_out_LZ = acc_q[5];
endmodule
